// File: rtl/pc_gen.sv
// pc_gen: program counter generator with trap/branch/stall priority and optional return-address stack (PC_GEN_RAS_EN).
// Ports: clk, reset (sync, active-high); stall, branch_taken, branch_target, trap_req, ras_push, ras_pop in;
// current_pc, next_pc, misaligned, bad_addr, ras_underflow out.
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0100_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0100_0100,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap_req,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr,
  output logic            ras_underflow
);
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] seq_pc;
  logic bad_target;
  logic mis_evt;
  logic advance;
  assign pc_plus4 = current_pc + XLEN'(4);
  assign bad_target = branch_target[1:0] != 2'b00;
  assign mis_evt = !trap_req && branch_taken && bad_target;
  assign advance = !(reset || stall || trap_req || branch_taken);
`ifdef PC_GEN_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
  logic [XLEN-1:0] stack [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0] count;
  logic [PW-1:0] top_idx;
  logic empty;
  logic hit;
  // ptr is the next free slot; the newest entry sits just below it, and wrapping overwrites the oldest
  assign top_idx = ptr - 1'b1;
  assign empty = count == '0;
  assign hit = ras_pop && !empty;
  assign seq_pc = hit ? stack[top_idx] : pc_plus4;
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      count <= '0;
      ras_underflow <= 1'b0;
    end else begin
      ras_underflow <= advance && ras_pop && empty;
      if (trap_req) count <= '0;
      else if (advance) begin
        if (ras_push && hit) stack[top_idx] <= pc_plus4;
        else if (ras_push) begin
          stack[ptr] <= pc_plus4;
          ptr <= ptr + 1'b1;
          count <= (count == FULL) ? count : count + 1'b1;
        end else if (hit) begin
          ptr <= top_idx;
          count <= count - 1'b1;
        end
      end
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ras_push ^ ras_pop;
  assign seq_pc = pc_plus4;
  assign ras_underflow = 1'b0;
`endif
  always_comb
    next_pc = reset ? RESET_VECTOR :
              trap_req ? TRAP_VECTOR :
              branch_taken ? (bad_target ? TRAP_VECTOR : branch_target) :
              stall ? current_pc : seq_pc;
  always_ff @(posedge clk) begin
    current_pc <= next_pc;
    if (reset) begin
      misaligned <= 1'b0;
      bad_addr <= '0;
    end else begin
      misaligned <= mis_evt;
      if (mis_evt) bad_addr <= branch_target;
    end
  end
endmodule
